// File: rtl/led_pkg.sv
// Shared types and defaults for the LED bank arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

  // Arbiter ownership phases: nobody, someone owns the bank, blanking gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int LED_W_DEF = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick enable every 2^TICK_DIV_W cycles.
// Latency: tick is registered, high the cycle after the counter reads all-ones.
// Backpressure: none; free-running.
// Ports: hwclk (clock), rst_n (async active-low reset), tick (one-cycle enable pulse).
module tick_prescaler #(
  parameter int TICK_DIV_W = 21
) (
  input  logic hwclk,
  input  logic rst_n,
  output logic tick
);

  logic [TICK_DIV_W-1:0] cnt;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + TICK_DIV_W'(1);
      tick <= &cnt;
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin, time-sliced arbiter sharing one LED bank between NUM_REQ pattern sources.
// Latency: grant 1 cycle after req is sampled, leds follow the owner's pattern 1 cycle later.
// Backpressure: requesters hold req until granted; owners are preempted after SLICE_TICKS ticks.
// Ports: hwclk, rst_n, req[NUM_REQ], pattern[NUM_REQ*LED_W] (source i at i*LED_W),
//        grant[NUM_REQ] (registered one-hot/zero), leds[LED_W] (registered), tick (prescaler pulse).
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = LED_W_DEF,
  parameter int TICK_DIV_W  = 21,
  parameter int SLICE_TICKS = 4
) (
  input  logic                     hwclk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         leds,
  output logic                     tick
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(SLICE_TICKS + 1);
  localparam logic [SW-1:0] SLICE_MAX = SW'(SLICE_TICKS);

  state_t                 state, state_nxt;
  logic [OW-1:0]          last_owner, last_nxt;
  logic [SW-1:0]          slice_cnt, slice_nxt;
  logic [NUM_REQ-1:0]     grant_nxt;
  logic [LED_W-1:0]       leds_nxt;
  logic [OW-1:0]          win;
  logic [NUM_REQ-1:0]     owner_oh;
  logic [NUM_REQ-1:0]     others;

  tick_prescaler #(.TICK_DIV_W(TICK_DIV_W)) u_prescaler (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Nearest set request after 'last', searching cyclically. Scanning from the
  // farthest candidate back towards the nearest lets the nearest one win.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      last);
    logic [OW-1:0] w;
    int            idx;
    w = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (r[idx]) w = OW'(idx);
    end
    return w;
  endfunction

  // In OWN, last_owner is the current owner.
  assign win      = rr_pick(req, last_owner);
  assign owner_oh = NUM_REQ'(1) << last_owner;
  assign others   = req & ~owner_oh;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    slice_nxt = slice_cnt;
    grant_nxt = grant;
    leds_nxt  = leds;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        leds_nxt  = '0;
        if (|req) begin
          state_nxt = OWN;
          grant_nxt = NUM_REQ'(1) << win;
          last_nxt  = win;
          slice_nxt = '0;
        end
      end
      OWN: begin
        grant_nxt = owner_oh;
        leds_nxt  = pattern[int'(last_owner)*LED_W +: LED_W];
        // Release beats slice expiry; both land in GAP, never a same-cycle re-grant.
        if (!req[last_owner]) begin
          state_nxt = GAP;
          grant_nxt = '0;
          leds_nxt  = '0;
        end else if (slice_cnt == SLICE_MAX) begin
          if (|others) begin
            state_nxt = GAP;
            grant_nxt = '0;
            leds_nxt  = '0;
          end else begin
            slice_nxt = '0;
          end
        end else if (tick) begin
          slice_nxt = slice_cnt + SW'(1);
        end
      end
      GAP: begin
        grant_nxt = '0;
        leds_nxt  = '0;
        if (tick) begin
          if (|req) begin
            state_nxt = OWN;
            grant_nxt = NUM_REQ'(1) << win;
            last_nxt  = win;
            slice_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        leds_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OW'(NUM_REQ - 1);
      slice_cnt  <= '0;
      grant      <= '0;
      leds       <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      slice_cnt  <= slice_nxt;
      grant      <= grant_nxt;
      leds       <= leds_nxt;
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomized bench for led_bank_arbiter against an ownership-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_bank_arbiter;

  localparam int NR   = 4;
  localparam int LW   = 8;
  localparam int TDW  = 4;
  localparam int ST   = 2;
  localparam int TPER = 1 << TDW;

  logic          hwclk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*LW-1:0] pattern;
  logic [NR-1:0] grant;
  logic [LW-1:0] leds;
  logic          tick;

  always #5 hwclk = ~hwclk;

  led_bank_arbiter #(
    .NUM_REQ     (NR),
    .LED_W       (LW),
    .TICK_DIV_W  (TDW),
    .SLICE_TICKS (ST)
  ) dut (
    .hwclk   (hwclk),
    .rst_n   (rst_n),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .leds    (leds),
    .tick    (tick)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bank (-1 = nobody), whether we are waiting
  // out a blanking gap, how many ticks the owner has held it, edges since reset.
  int          m_owner;
  int          m_held;
  int          m_last;
  int          m_cyc;
  bit          m_gap;
  logic [LW-1:0] m_leds;

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_last  = NR - 1;
    m_held  = 0;
    m_cyc   = 0;
    m_leds  = '0;
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++) begin
      if (r[(last + i) % NR]) return (last + i) % NR;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [NR-1:0] r, input logic [NR*LW-1:0] p);
    bit            tk;
    int            w;
    logic [NR-1:0] mask;
    tk = (m_cyc > 0) && (m_cyc % TPER == 0);
    w  = pick(r, m_last);
    if (m_owner >= 0) begin
      mask = ~(NR'(1) << m_owner);
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1'b1; m_leds = '0;
      end else if (m_held == ST && (r & mask) != 0) begin
        m_owner = -1; m_gap = 1'b1; m_leds = '0;
      end else if (m_held == ST) begin
        m_held = 0;
        m_leds = p[m_owner*LW +: LW];
      end else begin
        m_leds = p[m_owner*LW +: LW];
        if (tk) m_held++;
      end
    end else if (m_gap) begin
      if (tk) begin
        m_gap = 1'b0;
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 0;
        end
      end
    end else if (w >= 0) begin
      m_owner = w; m_last = w; m_held = 0;
    end
    m_cyc++;
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare on the falling edge.
  task automatic step(input logic [NR-1:0] r, input logic [NR*LW-1:0] p);
    logic [31:0] exp_grant;
    req     = r;
    pattern = p;
    model_step(r, p);
    @(posedge hwclk);
    @(negedge hwclk);
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant", 32'(grant), exp_grant);
    chk("leds",  32'(leds),  32'(m_leds));
    chk("tick",  32'(tick),  32'((m_cyc % TPER) == 0));
  endtask

  logic [NR-1:0]    rr;
  logic [NR*LW-1:0] pp;

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    pattern = '0;
    model_reset();
    repeat (3) @(negedge hwclk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_leds",  32'(leds),  32'd0);
    chk("rst_tick",  32'(tick),  32'd0);
    rst_n = 1'b1;

    // Idle with no requests: tick cadence only.
    repeat (40) step('0, '0);

    // Single owner, held well past five ticks, then a pattern change.
    repeat (90) step(4'b0100, 32'h00A5_0000);
    chk("single_a5", 32'(leds), 32'hA5);
    repeat (2) step(4'b0100, 32'h003C_0000);
    chk("single_3c", 32'(leds), 32'h3C);
    step('0, 32'h003C_0000);
    chk("release_grant", 32'(grant), 32'd0);
    repeat (20) step('0, '0);

    // Contention between requesters 0 and 1 from IDLE.
    repeat (80) step(4'b0011, 32'h0000_5AC3);

    // Release by requester 1 with requester 3 pending, then nothing pending.
    repeat (40) step(4'b0010, 32'h0000_5AC3);
    repeat (5)  step(4'b1010, 32'h7700_5AC3);
    repeat (30) step(4'b1000, 32'h7700_5AC3);
    repeat (30) step('0, '0);

    // Wrap-around: requester 3 owns, requester 0 joins; preemption wraps to 0.
    repeat (5)  step(4'b1000, 32'h1100_0022);
    repeat (60) step(4'b1001, 32'h1100_0022);

    // Randomized stretch with sticky requests so slices run to expiry.
    rr = '0;
    pp = $urandom;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(0, 23) == 0) rr[b] = ~rr[b];
      end
      if ($urandom_range(0, 7) == 0) pp = $urandom;
      step(rr, pp);
    end

    // Asynchronous reset in the middle of an ownership.
    repeat (40) step(4'b0100, 32'h00C6_0000);
    chk("own_before_rst", 32'(grant), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_leds",  32'(leds),  32'd0);
    chk("async_tick",  32'(tick),  32'd0);
    model_reset();
    @(negedge hwclk);
    rst_n = 1'b1;
    step(4'b0101, 32'h0099_0081);
    chk("rr_after_rst", 32'(grant), 32'b0001);
    repeat (40) step(4'b0101, 32'h0099_0081);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
